// File: rtl/full_leds_pwm_ctrl_pkg.sv
// Shared constants for the AXI4-Lite LED PWM controller:
// register offsets, ID word, response codes, channel decode.
package full_leds_pkg;

   localparam logic [6:0] ADDR_CTRL   = 7'h00;
   localparam logic [6:0] ADDR_BLINK  = 7'h04;
   localparam logic [6:0] ADDR_STATUS = 7'h08;
   localparam logic [6:0] ADDR_ID     = 7'h0C;
   localparam logic [6:0] ADDR_DUTY0  = 7'h10;

   localparam logic [31:0] ID_VALUE = 32'h1ED5_0002;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Word index -> channel; below DUTY0 wraps high and decodes as unmapped.
   function automatic logic [4:0] chan_idx(input logic [4:0] word);
      return word - ADDR_DUTY0[6:2];
   endfunction

endpackage

// File: rtl/full_leds_pwm_channel.sv
// One PWM channel: shadow duty reloaded at period wrap plus compare.
module full_leds_pwm_channel #(
   parameter int PWM_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [PWM_WIDTH-1:0] duty_i,
   input  logic [PWM_WIDTH-1:0] cnt_i,
   output logic                 pwm_on_o
);

   logic [PWM_WIDTH-1:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (load_i) shadow_d = duty_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end

   // Full-scale duty must be solid on, not off for the last count.
   always_comb begin
      pwm_on_o = 1'b0;
      unique case (1'b1)
         shadow_q == '0: pwm_on_o = 1'b0;
         &shadow_q:      pwm_on_o = 1'b1;
         default:        pwm_on_o = cnt_i < shadow_q;
      endcase
   end

endmodule

// File: rtl/full_leds_pwm_ctrl.sv
// AXI4-Lite LED controller: register file, prescaler, PWM counter,
// blink timer and registered LED outputs over NUM_LEDS channels.
module full_leds_pwm_ctrl
   import full_leds_pkg::*;
#(
   parameter int NUM_LEDS           = 8,
   parameter int PWM_WIDTH          = 8,
   parameter int PRESCALE           = 4,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_LEDS-1:0]             leds
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic clk, rst_n;
   assign clk   = s00_axi_aclk;
   assign rst_n = s00_axi_aresetn;

   logic unused_in;
   assign unused_in = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   logic                               awready_q, awready_d;
   logic                               bvalid_q, bvalid_d;
   logic [1:0]                         bresp_q, bresp_d;
   logic                               arready_q, arready_d;
   logic                               rvalid_q, rvalid_d;
   logic [1:0]                         rresp_q, rresp_d;
   logic [31:0]                        rdata_q, rdata_d;
   logic                               ctrl_en_q, ctrl_en_d;
   logic [31:0]                        blink_per_q, blink_per_d;
   logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] duty_q, duty_d;
   logic [NUM_LEDS-1:0]                blink_en_q, blink_en_d;
   logic [PS_W-1:0]                    presc_q, presc_d;
   logic [PWM_WIDTH-1:0]               pwm_cnt_q, pwm_cnt_d;
   logic [31:0]                        blink_cnt_q, blink_cnt_d;
   logic                               phase_q, phase_d;
   logic [NUM_LEDS-1:0]                leds_q, leds_d;

   logic                wr_en, wr_ok, wr_duty, blink_wr;
   logic [4:0]          wr_word, wr_ci;
   logic [31:0]         bm;
   logic                rd_en, rd_ok;
   logic [4:0]          rd_word, rd_ci;
   logic [31:0]         rd_val;
   logic                tick, pwm_wrap;
   logic [NUM_LEDS-1:0] pwm_on;

   // Write path: address and data are taken together.
   assign wr_en   = awready_q & s00_axi_awvalid & s00_axi_wvalid;
   assign wr_word = s00_axi_awaddr[6:2];
   assign wr_ci   = chan_idx(wr_word);
   assign wr_duty = wr_ci < 5'(NUM_LEDS);
   assign wr_ok   = (wr_word == ADDR_CTRL[6:2]) |
                    (wr_word == ADDR_BLINK[6:2]) | wr_duty;
   assign blink_wr = wr_en & (wr_word == ADDR_BLINK[6:2]);
   assign bm = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};

   always_comb begin
      awready_d = ~awready_q & s00_axi_awvalid &
                  s00_axi_wvalid & ~bvalid_q;
      bvalid_d  = bvalid_q & ~s00_axi_bready;
      bresp_d   = bresp_q;
      if (wr_en) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_comb begin
      ctrl_en_d   = ctrl_en_q;
      blink_per_d = blink_per_q;
      duty_d      = duty_q;
      blink_en_d  = blink_en_q;
      if (wr_en) begin
         if (wr_word == ADDR_CTRL[6:2] && s00_axi_wstrb[0])
            ctrl_en_d = s00_axi_wdata[0];
         if (wr_word == ADDR_BLINK[6:2])
            blink_per_d = (blink_per_q & ~bm) | (s00_axi_wdata & bm);
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_duty && wr_ci == 5'(i)) begin
               duty_d[i] = (duty_q[i] & ~bm[PWM_WIDTH-1:0]) |
                           (s00_axi_wdata[PWM_WIDTH-1:0] &
                            bm[PWM_WIDTH-1:0]);
               if (s00_axi_wstrb[3]) blink_en_d[i] = s00_axi_wdata[31];
            end
         end
      end
   end

   // Read path: data sampled from current state, so a same-cycle
   // write to the same register is not yet visible.
   assign rd_en   = arready_q & s00_axi_arvalid;
   assign rd_word = s00_axi_araddr[6:2];
   assign rd_ci   = chan_idx(rd_word);

   always_comb begin
      rd_val = '0;
      rd_ok  = 1'b1;
      unique case (1'b1)
         rd_word == ADDR_CTRL[6:2]:  rd_val[0] = ctrl_en_q;
         rd_word == ADDR_BLINK[6:2]: rd_val = blink_per_q;
         rd_word == ADDR_STATUS[6:2]: begin
            rd_val[NUM_LEDS-1:0] = leds_q;
            rd_val[16]           = phase_q;
         end
         rd_word == ADDR_ID[6:2]:    rd_val = ID_VALUE;
         rd_ci < 5'(NUM_LEDS): begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               if (rd_ci == 5'(i)) begin
                  rd_val[PWM_WIDTH-1:0] = duty_q[i];
                  rd_val[31]            = blink_en_q[i];
               end
            end
         end
         default: rd_ok = 1'b0;
      endcase
   end

   always_comb begin
      arready_d = ~arready_q & s00_axi_arvalid & ~rvalid_q;
      rvalid_d  = rvalid_q & ~s00_axi_rready;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Timebase: prescaler feeds the PWM counter; blink runs on raw clock.
   assign tick     = presc_q == PS_W'(PRESCALE - 1);
   assign pwm_wrap = tick & (&pwm_cnt_q);

   always_comb begin
      presc_d     = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
      blink_cnt_d = blink_cnt_q + 32'd1;
      phase_d     = phase_q;
      if (blink_wr) begin
         blink_cnt_d = '0;
      end else if (blink_per_q <= 32'd1 ||
                   blink_cnt_q == blink_per_q - 32'd1) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
      full_leds_pwm_channel #(
         .PWM_WIDTH(PWM_WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (pwm_wrap),
         .duty_i  (duty_q[g]),
         .cnt_i   (pwm_cnt_q),
         .pwm_on_o(pwm_on[g])
      );
   end

   always_comb begin
      leds_d = {NUM_LEDS{ctrl_en_q}} & pwm_on &
               (~blink_en_q | {NUM_LEDS{phase_q}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rresp_q     <= RESP_OKAY;
         rdata_q     <= '0;
         ctrl_en_q   <= 1'b0;
         blink_per_q <= '0;
         duty_q      <= '0;
         blink_en_q  <= '0;
         presc_q     <= '0;
         pwm_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         leds_q      <= '0;
      end else begin
         awready_q   <= awready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         ctrl_en_q   <= ctrl_en_d;
         blink_per_q <= blink_per_d;
         duty_q      <= duty_d;
         blink_en_q  <= blink_en_d;
         presc_q     <= presc_d;
         pwm_cnt_q   <= pwm_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         leds_q      <= leds_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rresp   = rresp_q;
   assign s00_axi_rdata   = rdata_q;
   assign leds            = leds_q;

endmodule

// File: tb/tb_full_leds_pwm_ctrl.sv
// Self-checking bench for full_leds_pwm_ctrl: AXI register model,
// PWM on-count, glitch-free reload, blink timing and error responses.
module tb_full_leds_pwm_ctrl;

   localparam int NL = 8;
   localparam int PW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [NL-1:0] leds;

   int compared = 0;
   int mismatched = 0;
   logic [31:0] mdl [32];
   int n, c0, c1;
   int cnt [4];
   logic prev, hit;
   logic [31:0] d, old;
   logic [1:0] r;

   always #5 clk = ~clk;

   full_leds_pwm_ctrl #(
      .NUM_LEDS(NL), .PWM_WIDTH(PW), .PRESCALE(4)
   ) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr (awaddr),
      .s00_axi_awprot (awprot),
      .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready),
      .s00_axi_wdata  (wdata),
      .s00_axi_wstrb  (wstrb),
      .s00_axi_wvalid (wvalid),
      .s00_axi_wready (wready),
      .s00_axi_bresp  (bresp),
      .s00_axi_bvalid (bvalid),
      .s00_axi_bready (bready),
      .s00_axi_araddr (araddr),
      .s00_axi_arprot (arprot),
      .s00_axi_arvalid(arvalid),
      .s00_axi_arready(arready),
      .s00_axi_rdata  (rdata),
      .s00_axi_rresp  (rresp),
      .s00_axi_rvalid (rvalid),
      .s00_axi_rready (rready),
      .leds           (leds)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%08h expected=0x%08h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input int w);
      if (w == 0) return 32'h1;
      if (w == 1) return 32'hFFFF_FFFF;
      if (w >= 4 && w < 4 + NL)
         return 32'h8000_0000 | ((32'h1 << PW) - 32'h1);
      return 32'h0;
   endfunction

   task automatic axi_write(input logic [6:0] a, input logic [31:0] v,
                            input logic [3:0] s, output logic [1:0] rs);
      int k;
      @(negedge clk);
      awaddr = a; wdata = v; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      k = 0;
      while (!awready && k < 50) begin @(negedge clk); k++; end
      chk("aw_wait", 32'(k < 50), 32'h1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      k = 0;
      while (!bvalid && k < 50) begin @(negedge clk); k++; end
      chk("b_wait", 32'(k < 50), 32'h1);
      rs = bresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [6:0] a, output logic [31:0] v,
                           output logic [1:0] rs);
      int k;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      k = 0;
      while (!arready && k < 50) begin @(negedge clk); k++; end
      chk("ar_wait", 32'(k < 50), 32'h1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < 50) begin @(negedge clk); k++; end
      chk("r_wait", 32'(k < 50), 32'h1);
      v = rdata; rs = rresp;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] v,
                     input logic [3:0] s);
      logic [1:0]  rs;
      logic [31:0] m, b;
      int w;
      w = int'(a[6:2]);
      m = wmask(w);
      for (int k = 0; k < 4; k++) b[8*k +: 8] = {8{s[k]}};
      axi_write(a, v, s, rs);
      chk($sformatf("bresp_%02h", a), 32'(rs),
          (m != 0) ? 32'h0 : 32'h2);
      if (m != 0) mdl[w] = ((mdl[w] & ~b) | (v & b)) & m;
   endtask

   task automatic rd(input logic [6:0] a, output logic [31:0] v);
      logic [1:0] rs;
      int w;
      logic ok;
      w = int'(a[6:2]);
      ok = (w <= 3) || (wmask(w) != 0);
      axi_read(a, v, rs);
      chk($sformatf("rresp_%02h", a), 32'(rs), ok ? 32'h0 : 32'h2);
      if (w == 3)
         chk("id", v, 32'h1ED5_0002);
      else if (w != 2)
         chk($sformatf("rdata_%02h", a), v, ok ? mdl[w] : 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = '0; wstrb = '0;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      repeat (4) @(negedge clk);
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_hs", {28'h0, awready, bvalid, arready, rvalid}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      rd(7'h0C, d);
      rd(7'h00, d);
      chk("leds_idle", 32'(leds), 32'h0);

      wr(7'h10, 32'h00, 4'hF);
      wr(7'h14, 32'h40, 4'hF);
      wr(7'h18, 32'h80, 4'hF);
      wr(7'h1C, 32'hFF, 4'hF);
      wr(7'h00, 32'h1, 4'hF);
      repeat (1100) @(negedge clk);
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      c0 = 0;
      for (int i = 0; i < 1024; i++) begin
         for (int k = 0; k < 4; k++) cnt[k] += int'(leds[k]);
         if (leds[NL-1:4] != '0) c0++;
         @(negedge clk);
      end
      chk("on_cnt0", cnt[0], 0);
      chk("on_cnt1", cnt[1], 256);
      chk("on_cnt2", cnt[2], 512);
      chk("on_cnt3", cnt[3], 1024);
      chk("on_idle_ch", c0, 0);

      prev = leds[1]; n = 0; hit = 1'b0;
      while (!hit && n < 3000) begin
         @(negedge clk); n++;
         hit = !prev && leds[1];
         prev = leds[1];
      end
      chk("duty1_edge", 32'(hit), 32'h1);
      c0 = 0; c1 = 0;
      fork
         begin
            for (int i = 0; i < 2048; i++) begin
               if (i < 1024) c0 += int'(leds[1]);
               else          c1 += int'(leds[1]);
               @(negedge clk);
            end
         end
         begin
            repeat (300) @(negedge clk);
            wr(7'h14, 32'h80, 4'hF);
         end
      join
      chk("reload_cur", c0, 256);
      chk("reload_next", c1, 512);

      wr(7'h04, 32'd100, 4'hF);
      wr(7'h18, 32'h8000_00FF, 4'hF);
      repeat (1100) @(negedge clk);
      prev = leds[2]; n = 0; hit = 1'b0;
      while (!hit && n < 400) begin
         @(negedge clk); n++;
         hit = !prev && leds[2];
         prev = leds[2];
      end
      chk("blink_edge", 32'(hit), 32'h1);
      n = 0;
      while (leds[2] && n < 300) begin n++; @(negedge clk); end
      chk("blink_on", n, 100);
      n = 0;
      while (!leds[2] && n < 300) begin n++; @(negedge clk); end
      chk("blink_off", n, 100);
      repeat (20) @(negedge clk);
      rd(7'h08, d);
      chk("status_hi", {30'h0, d[16], d[2]}, 32'h3);
      repeat (100) @(negedge clk);
      rd(7'h08, d);
      chk("status_lo", {30'h0, d[16], d[2]}, 32'h0);

      wr(7'h7C, $urandom, 4'hF);
      wr(7'h08, $urandom, 4'hF);
      rd(7'h7C, d);
      rd(7'h00, d);
      rd(7'h04, d);

      @(negedge clk);
      awaddr = 7'h00; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      chk("hold_aw", 32'(n < 50), 32'h1);
      @(posedge clk); #1;
      awaddr = 7'h24; wdata = 32'h33;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("b_hold", {30'h0, bvalid, awready}, 32'h2);
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(posedge clk); #1;
      chk("b_release", 32'(bvalid), 32'h0);
      rd(7'h24, d);

      old = mdl[5];
      fork
         wr(7'h14, 32'h8000_0011, 4'hF);
         axi_read(7'h14, d, r);
      join
      chk("rw_same_old", d, old);
      rd(7'h14, d);

      wr(7'h10, 32'hFFFF_FFAA, 4'b0001);
      rd(7'h10, d);
      chk("strb_duty0", d, 32'h0000_00AA);

      wr(7'h00, 32'h0, 4'hF);
      repeat (2) @(negedge clk);
      chk("disable", 32'(leds), 32'h0);

      for (int i = 0; i < 60; i++) begin
         logic [6:0] a;
         a = {5'($urandom_range(0, 31)), 2'b00};
         if ($urandom_range(0, 1) == 1)
            wr(a, $urandom, 4'($urandom));
         else
            rd(a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/full_leds_pwm_ctrl.md
FULL_LEDS_PWM_CTRL -- requirements
Module: full_leds_pwm_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of LED channels (legal 1..16).
REQ-002 SHALL have parameter PWM_WIDTH, default 8, duty/PWM counter width (legal 4..16).
REQ-003 SHALL have parameter PRESCALE, default 4, clock cycles per PWM counter step (legal 1..65535).
REQ-004 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, fixed AXI4-Lite data width.
REQ-005 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, byte address width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports s00_axi_aclk (input, 1) and s00_axi_aresetn (input, 1).
REQ-007 SHALL have the standard AXI4-Lite slave ports s00_axi_aw*/w*/b*/ar*/r*, including awprot/arprot, which are ignored, and wstrb (4 bits).
REQ-008 SHALL have output leds, NUM_LEDS bits, active-high LED drive.

Function
REQ-009 Register map: 0x00 CTRL (bit0 global enable), 0x04 BLINK_PERIOD (32-bit, counted in clock cycles), 0x08 STATUS (read-only: [NUM_LEDS-1:0] current leds, bit16 blink phase), 0x0C ID (read-only, constant 0x1ED5_0002), 0x10+4*i DUTY[i] for i < NUM_LEDS ([PWM_WIDTH-1:0] duty, bit31 blink enable).
REQ-010 Write: AWREADY and WREADY SHALL assert together for exactly one cycle, only once both AWVALID and WVALID are high and BVALID is low.
REQ-011 Register update SHALL happen in the same cycle as the AW/W acceptance, per byte as enabled by WSTRB; unimplemented bits SHALL read 0.
REQ-012 BVALID SHALL assert the cycle after acceptance and SHALL hold until BREADY; BRESP SHALL be OKAY for mapped writable addresses and SLVERR otherwise (including STATUS, ID and unmapped addresses), with no state change on SLVERR.
REQ-013 Read: ARREADY SHALL pulse for one cycle when ARVALID is high and RVALID is low; RVALID SHALL assert the next cycle with registered RDATA and SHALL hold until RREADY.
REQ-014 RRESP SHALL be OKAY for mapped addresses; unmapped reads SHALL return RDATA 0 with SLVERR.
REQ-015 Simultaneous read and write acceptance SHALL both proceed; a read of the same address in that cycle SHALL return the old value.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 and emit a tick at wrap.
REQ-017 The PWM counter (PWM_WIDTH bits) SHALL increment on each tick, wrapping from all-ones to 0.
REQ-018 Each channel SHALL hold a shadow duty, loaded from DUTY[i] only in the cycle the PWM counter wraps to 0, so that mid-period writes are glitch-free.
REQ-019 pwm_on[i] SHALL equal (counter < shadow), with two exceptions: shadow == 0 SHALL give always off, and shadow == all-ones SHALL give always on.
REQ-020 The blink counter SHALL count clock cycles; on reaching BLINK_PERIOD-1 it SHALL reset to 0 and toggle the blink phase. A BLINK_PERIOD of 0 or 1 SHALL toggle the phase every cycle.
REQ-021 A BLINK_PERIOD write SHALL clear the blink counter.
REQ-022 leds[i] SHALL be registered as CTRL.enable & pwm_on[i] & (~blink_en[i] | phase), giving one cycle of latency from the internal state.
REQ-023 Clearing CTRL.enable SHALL force leds to 0 on the next cycle; the counters SHALL keep running.

Reset
REQ-024 On s00_axi_aresetn low, all of the following SHALL clear asynchronously: registers, shadows, counters and phase, plus all AXI READY/VALID outputs, BRESP/RRESP/RDATA, and leds.
REQ-025 Deassertion SHALL be synchronised by the system; the first AXI handshake is legal 1 cycle after deassertion.
REQ-026 Reset during an outstanding B/R response SHALL drop VALID immediately with no response replay.

Structure
REQ-027 Package full_leds_pkg SHALL hold the register offsets, the ID constant, the RESP codes (OKAY = 2'b00, SLVERR = 2'b10), and the channel-index function.
REQ-028 Sub-module full_leds_pwm_channel SHALL contain the shadow duty and compare logic for one channel; the top level SHALL generate NUM_LEDS instances.
REQ-029 The AXI interface, prescaler, PWM counter, and blink logic SHALL reside in the top level.

Verification
REQ-030 Reset, then read ID and CTRL -> 0x1ED50002 and 0x0 respectively, both OKAY; leds == 0.
REQ-031 Write DUTY[0..3] = 0x00, 0x40, 0x80, 0xFF and CTRL = 1 (PWM_WIDTH 8, PRESCALE 4) -> over 1024 cycles the on-counts SHALL be exactly 0, 256, 512 and 1024.
REQ-032 Write DUTY[1] = 0x80 mid-period while it is 0x40 -> the current period SHALL keep a 64-tick high, and the next period SHALL show 128.
REQ-033 Write BLINK_PERIOD = 100 and DUTY[2] = 0x8000_00FF -> leds[2] SHALL alternate 100 cycles on and 100 cycles off; STATUS bit16 SHALL track the phase.
REQ-034 Write 0x7C (unmapped) and 0x08 (STATUS) -> SLVERR, no register change; a read of 0x7C -> RDATA 0 with SLVERR; BREADY held low for 10 cycles -> BVALID SHALL stay high and no new AW SHALL be accepted.
REQ-035 Write with WSTRB = 4'b0001 of 0xFFFF_FFAA to DUTY[0] -> DUTY[0] reads back as 0x0000_00AA.
